// File: rtl/cpu_control_fsm_pkg.sv
// Shared definitions for the simple_cpu control unit: opcodes, ALU ops,
// register-file write sources, FSM states and the decoded-instruction bundle.
package cpu_control_fsm_pkg;

  // Instruction opcodes (ir[7:4]); 9..E are undefined and run as NOP.
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_MOV = 4'h5;
  localparam logic [3:0] OP_LDI = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_PASS = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    WSEL_ALU = 2'd0,
    WSEL_IMM = 2'd1,
    WSEL_B   = 2'd2
  } wsel_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_IMM,
    S_EXEC,
    S_WB,
    S_HALT
  } state_e;

  // Instruction class flags produced by the decoder.
  typedef struct packed {
    logic    is_alu;
    logic    is_mov;
    logic    needs_imm;
    logic    is_ldi;
    logic    is_jmp;
    logic    is_jz;
    logic    is_hlt;
    logic    illegal;
    alu_op_e alu_op;
  } decode_t;

endpackage

// File: rtl/cpu_control_fsm_decoder.sv
// Combinational opcode decoder: classifies the latched opcode for the FSM.
module cpu_control_fsm_decoder
  import cpu_control_fsm_pkg::*;
(
  input  logic [3:0] opcode,
  output decode_t    dec
);

  // Map each opcode to its class flags and ALU operation.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    dec        = '0;
    dec.alu_op = ALU_ADD;
    case (opcode)
      OP_NOP: ;
      OP_ADD: begin dec.is_alu = 1'b1; dec.alu_op = ALU_ADD; end
      OP_SUB: begin dec.is_alu = 1'b1; dec.alu_op = ALU_SUB; end
      OP_AND: begin dec.is_alu = 1'b1; dec.alu_op = ALU_AND; end
      OP_OR:  begin dec.is_alu = 1'b1; dec.alu_op = ALU_OR;  end
      OP_MOV: begin dec.is_mov = 1'b1; dec.alu_op = ALU_PASS; end
      OP_LDI: begin dec.needs_imm = 1'b1; dec.is_ldi = 1'b1; end
      OP_JMP: begin dec.needs_imm = 1'b1; dec.is_jmp = 1'b1; end
      OP_JZ:  begin dec.needs_imm = 1'b1; dec.is_jz  = 1'b1; end
      OP_HLT: dec.is_hlt = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control unit for simple_cpu: fetches 1- or 2-byte instructions,
// holds IR/IMM and sequences PC, register file, ALU and zero flag.
module cpu_control_fsm
  import cpu_control_fsm_pkg::*;
#(
  parameter int PC_W   = 4,
  parameter int DATA_W = 8,
  parameter int RA_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_en,
  input  logic [DATA_W-1:0] instr,
  input  logic              zero_flag,
  output logic              pc_inc,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_load_val,
  output logic [RA_W-1:0]   rf_raddr_a,
  output logic [RA_W-1:0]   rf_raddr_b,
  output logic              rf_we,
  output logic [RA_W-1:0]   rf_waddr,
  output logic [1:0]        rf_wsel,
  output logic [DATA_W-1:0] imm,
  output logic [2:0]        alu_op,
  output logic              flag_we,
  output logic              illegal,
  output logic              halted
);

  state_e            state, state_nxt;
  logic [DATA_W-1:0] ir;
  logic              ir_load, imm_load;
  decode_t           dec;

  cpu_control_fsm_decoder u_decoder (
    .opcode (ir[DATA_W-1 -: 4]),
    .dec    (dec)
  );

  // Register fields come straight from IR, so they stay stable EXEC through WB.
  assign rf_raddr_a  = ir[3:2];
  assign rf_raddr_b  = ir[1:0];
  assign rf_waddr    = ir[3:2];
  assign pc_load_val = imm[PC_W-1:0];

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // Instruction and immediate registers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: IR/IMM are plain registers (not a memory array), so they take the reset and read back 0.
    if (reset) begin
      ir  <= '0;
      imm <= '0;
    end else begin
      if (ir_load)  ir  <= instr;
      if (imm_load) imm <= instr;
    end
  end

  // Next-state and strobe decode from state + IR.
  always_comb begin
    state_nxt = state;
    ir_load   = 1'b0;
    imm_load  = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    rf_we     = 1'b0;
    rf_wsel   = WSEL_ALU;
    alu_op    = ALU_ADD;
    flag_we   = 1'b0;
    illegal   = 1'b0;
    halted    = 1'b0;
    case (state)
      S_FETCH: begin
        // Gate with reset so no PC step is requested while reset is held.
        if (run_en && !reset) begin
          ir_load   = 1'b1;
          pc_inc    = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        illegal = dec.illegal;
        if (dec.is_hlt)                  state_nxt = S_HALT;
        else if (dec.needs_imm)          state_nxt = S_IMM;
        else if (dec.is_alu || dec.is_mov) state_nxt = S_EXEC;
        else                             state_nxt = S_FETCH;
      end
      S_IMM: begin
        imm_load  = 1'b1;
        pc_inc    = 1'b1;
        state_nxt = dec.is_ldi ? S_WB : S_EXEC;
      end
      S_EXEC: begin
        if (dec.is_alu || dec.is_mov) begin
          alu_op    = dec.alu_op;
          state_nxt = S_WB;
        end else begin
          pc_load   = dec.is_jmp || (dec.is_jz && zero_flag);
          state_nxt = S_FETCH;
        end
      end
      S_WB: begin
        rf_we = 1'b1;
        if (dec.is_alu || dec.is_mov) alu_op = dec.alu_op;
        flag_we = dec.is_alu;
        if (dec.is_ldi)      rf_wsel = WSEL_IMM;
        else if (dec.is_mov) rf_wsel = WSEL_B;
        else                 rf_wsel = WSEL_ALU;
        state_nxt = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_nxt = S_FETCH;
    endcase
  end

endmodule
